// File: rtl/force_readout_sequencer_pkg.sv
// Shared constants and types for the per-cell force readout sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package force_readout_sequencer_pkg;

    // Default molecular-dynamics datapath dimensions.
    localparam int MD_PARTICLE_ID_WIDTH  = 8;
    localparam int MD_FLOAT_STRUCT_WIDTH = 32;
    localparam int MD_NUM_PES_PER_CELL   = 2;

    // One readout word: neighbour force on top of all home-lane forces.
    localparam int FRC_READOUT_WIDTH = MD_FLOAT_STRUCT_WIDTH * (MD_NUM_PES_PER_CELL + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_ISSUE = 2'd2,
        ST_FLUSH = 2'd3
    } rd_state_e;

endpackage

// File: rtl/frc_readout_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// Latency: pop_vld rises the cycle after a push into an empty FIFO.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
//
// Ports: push/push_dat write side, pop/pop_dat/pop_vld read side (pop_dat is
// the head entry, zero while empty), full and count report occupancy.
module frc_readout_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     pop_vld,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign pop_vld = (count != '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && pop_vld;
    // When full, a simultaneous pop frees the slot being overwritten; the head
    // has already been consumed combinationally this cycle.
    assign do_push = push && (!full || do_pop);
    assign pop_dat = pop_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/force_readout_sequencer.sv
// Drains the force cache after force evaluation, reads particles 0..N-1 and streams {nb, home} forces to MU.
// Latency: first read DRAIN_QUIET_CYCLES+2 after start; data reaches MU one cycle after the cache returns it.
// Backpressure: reads are credit-limited so returned data never exceeds the FIFO; MU stalls via i_frc_out_ready.
//
// Ports: i_start/i_num_particles launch a run; i_*_buf_empty gate the drain;
// o_MU_rd_* read the cache; i_home_frc/i_nb_frc/i_frc_valid carry returns;
// o_frc_* / i_frc_out_ready form the MU handshake; o_busy/o_done/o_err status.
module force_readout_sequencer
    import force_readout_sequencer_pkg::*;
#(
    parameter int PARTICLE_ID_WIDTH  = MD_PARTICLE_ID_WIDTH,
    parameter int FLOAT_STRUCT_WIDTH = MD_FLOAT_STRUCT_WIDTH,
    parameter int NUM_PES_PER_CELL   = MD_NUM_PES_PER_CELL,
    parameter int FIFO_DEPTH         = 8,
    parameter int DRAIN_QUIET_CYCLES = 4
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic                                              i_start,
    input  logic [PARTICLE_ID_WIDTH:0]                        i_num_particles,
    input  logic                                              i_home_buf_empty,
    input  logic                                              i_nb_buf_empty,
    output logic [PARTICLE_ID_WIDTH-1:0]                      o_MU_rd_addr,
    output logic                                              o_MU_rd_en,
    input  logic [FLOAT_STRUCT_WIDTH*NUM_PES_PER_CELL-1:0]    i_home_frc,
    input  logic [FLOAT_STRUCT_WIDTH-1:0]                     i_nb_frc,
    input  logic                                              i_frc_valid,
    output logic [FLOAT_STRUCT_WIDTH*(NUM_PES_PER_CELL+1)-1:0] o_frc_data,
    output logic [PARTICLE_ID_WIDTH-1:0]                      o_frc_parid,
    output logic                                              o_frc_out_valid,
    input  logic                                              i_frc_out_ready,
    output logic                                              o_busy,
    output logic                                              o_done,
    output logic                                              o_err
);

    localparam int DW = FLOAT_STRUCT_WIDTH * (NUM_PES_PER_CELL + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int QW = $clog2(DRAIN_QUIET_CYCLES + 1);
    localparam int NW = PARTICLE_ID_WIDTH + 1;
    localparam logic [NW-1:0] N_MAX = NW'(1) << PARTICLE_ID_WIDTH;

    rd_state_e state_q, state_d;

    logic [NW-1:0] num_q, issue_cnt_q, pop_cnt_q;
    logic [QW-1:0] quiet_q;
    logic [CW-1:0] outst_q, fifo_count;
    logic [CW:0]   credit_sum;
    logic          both_empty, quiet_term, credit_ok, last_issue;
    logic          start_acc, issue_fire, finish;
    logic          ret_ok, push, pop, fifo_full, overflow;
    logic          rd_en_q, done_q, err_q;
    logic [PARTICLE_ID_WIDTH-1:0] rd_addr_q;

    assign both_empty = i_home_buf_empty && i_nb_buf_empty;
    // Terminal is detected on the edge that completes the quiet run, so the
    // state leaves DRAIN exactly as the counter would hit its limit.
    assign quiet_term = both_empty && (quiet_q == QW'(DRAIN_QUIET_CYCLES - 1));
    assign credit_sum = {1'b0, outst_q} + {1'b0, fifo_count};
    assign credit_ok  = credit_sum < (CW+1)'(FIFO_DEPTH);
    assign last_issue = (issue_cnt_q == num_q - NW'(1));

    // Returns with nothing in flight are spurious and dropped.
    assign ret_ok   = i_frc_valid && (outst_q != '0);
    assign pop      = o_frc_out_valid && i_frc_out_ready;
    assign push     = ret_ok && (!fifo_full || pop);
    assign overflow = ret_ok && fifo_full && !pop;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (i_start) state_d = ST_DRAIN;
            ST_DRAIN: if (quiet_term) state_d = (num_q == '0) ? ST_IDLE : ST_ISSUE;
            ST_ISSUE: if (credit_ok && last_issue) state_d = ST_FLUSH;
            ST_FLUSH: if (pop_cnt_q == num_q) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ---------------- state-decoded controls ----------------
    always_comb begin
        start_acc  = 1'b0;
        issue_fire = 1'b0;
        finish     = 1'b0;
        o_busy     = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE:  start_acc  = i_start;
            ST_DRAIN: finish     = quiet_term && (num_q == '0);
            ST_ISSUE: issue_fire = credit_ok;
            ST_FLUSH: finish     = (pop_cnt_q == num_q);
            default:  ;
        endcase
    end

    // ---------------- counters and registered outputs ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_q       <= '0;
            quiet_q     <= '0;
            issue_cnt_q <= '0;
            pop_cnt_q   <= '0;
            outst_q     <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (start_acc) begin
                num_q       <= (i_num_particles > N_MAX) ? N_MAX : i_num_particles;
                issue_cnt_q <= '0;
                pop_cnt_q   <= '0;
            end else begin
                if (issue_fire) issue_cnt_q <= issue_cnt_q + NW'(1);
                if (pop)        pop_cnt_q   <= pop_cnt_q + NW'(1);
            end

            if (state_q == ST_DRAIN && both_empty) quiet_q <= quiet_q + QW'(1);
            else                                   quiet_q <= '0;

            // Counted at the issue decision so the next cycle's credit check
            // already sees the read that is about to go out.
            case ({issue_fire, ret_ok})
                2'b10:   outst_q <= outst_q + CW'(1);
                2'b01:   outst_q <= outst_q - CW'(1);
                default: outst_q <= outst_q;
            endcase

            rd_en_q <= issue_fire;
            if (issue_fire) rd_addr_q <= issue_cnt_q[PARTICLE_ID_WIDTH-1:0];

            done_q <= finish;
            err_q  <= err_q || (i_frc_valid && outst_q == '0) || overflow;
        end
    end

    frc_readout_fifo #(
        .WIDTH (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat ({i_nb_frc, i_home_frc}),
        .pop      (pop),
        .pop_dat  (o_frc_data),
        .pop_vld  (o_frc_out_valid),
        .full     (fifo_full),
        .count    (fifo_count)
    );

    assign o_MU_rd_en   = rd_en_q;
    assign o_MU_rd_addr = rd_addr_q;
    assign o_frc_parid  = pop_cnt_q[PARTICLE_ID_WIDTH-1:0];
    assign o_done       = done_q;
    assign o_err        = err_q;

endmodule
